// File: rtl/alto_microsequencer_pkg.sv
// Shared architectural constants and types for the Alto microsequencer.
package alto_microsequencer_pkg;

  localparam int          ALTO_MPC_WIDTH     = 10;
  localparam int          ALTO_TASK_COUNT    = 16;
  localparam logic [3:0]  ALTO_F1_TASK       = 4'h2;
  localparam logic [3:0]  ALTO_TASK_EMULATOR = 4'd0;

  typedef logic [ALTO_MPC_WIDTH-1:0] mpc_t;
  typedef logic [3:0]                task_t;

endpackage

// File: rtl/alto_task_priority.sv
// Combinational 16->4 priority encoder; the emulator request (bit 0) is always present.
module alto_task_priority
  import alto_microsequencer_pkg::*;
(
  input  logic [15:0] wakeup_i,
  output logic [3:0]  task_o
);

  logic [15:0] req;

  assign req = wakeup_i | 16'h0001;

  // Later (higher-numbered) hits override earlier ones.
  always_comb begin
    task_o = ALTO_TASK_EMULATOR;
    for (int i = 0; i < ALTO_TASK_COUNT; i++) begin
      if (req[i]) task_o = 4'(i);
    end
  end

endmodule

// File: rtl/alto_microsequencer.sv
// Control-store address sequencer: per-task saved MPCs, NEXT|modifier addressing, TASK switching.
module alto_microsequencer
  import alto_microsequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic [15:0] wakeup_i,
  input  logic [3:0]  f1_i,
  input  logic [9:0]  next_i,
  input  logic [9:0]  modifiers_i,
  output logic [9:0]  mpc_o,
  output logic [3:0]  current_task_o,
  output logic [3:0]  next_task_o,
  output logic        task_switch_o
);

  mpc_t  mpc_q, mpc_d;
  task_t cur_task_q, cur_task_d;
  task_t next_task_q, next_task_d;
  logic  task_switch_q, task_switch_d;
  mpc_t  save_q [ALTO_TASK_COUNT];
  mpc_t  save_d [ALTO_TASK_COUNT];

  task_t prio_task;
  mpc_t  target;

  alto_task_priority u_prio (
    .wakeup_i (wakeup_i),
    .task_o   (prio_task)
  );

  assign target = next_i | modifiers_i;

  always_comb begin
    mpc_d         = mpc_q;
    cur_task_d    = cur_task_q;
    next_task_d   = next_task_q;
    task_switch_d = task_switch_q;
    save_d        = save_q;
    if (!stall_i) begin
      next_task_d        = prio_task;
      save_d[cur_task_q] = target;
      mpc_d              = target;
      task_switch_d      = 1'b0;
      if (f1_i == ALTO_F1_TASK) begin
        cur_task_d = next_task_q;
        // Self-switch bypasses the save array, whose entry is being overwritten this cycle.
        if (next_task_q != cur_task_q) begin
          mpc_d         = save_q[next_task_q];
          task_switch_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mpc_q         <= '0;
      cur_task_q    <= ALTO_TASK_EMULATOR;
      next_task_q   <= ALTO_TASK_EMULATOR;
      task_switch_q <= 1'b0;
      for (int n = 0; n < ALTO_TASK_COUNT; n++) begin
        save_q[n] <= mpc_t'(n);
      end
    end else begin
      mpc_q         <= mpc_d;
      cur_task_q    <= cur_task_d;
      next_task_q   <= next_task_d;
      task_switch_q <= task_switch_d;
      save_q        <= save_d;
    end
  end

  assign mpc_o          = mpc_q;
  assign current_task_o = cur_task_q;
  assign next_task_o    = next_task_q;
  assign task_switch_o  = task_switch_q;

endmodule
